// File: rtl/binary_mul_n_1_bi_if.sv
// binary_mul_n_1_bi_if: operand/result bundle for the shift-add multiplier
interface binary_mul_n_1_bi_if #(parameter int WIDTH = 8);
  logic en, start, sgn, busy, done;
  logic [WIDTH-1:0] A, B;
  logic [2*WIDTH-1:0] P;
  modport master(output en, start, sgn, A, B, input busy, done, P);
  modport slave(input en, start, sgn, A, B, output busy, done, P);
endinterface

// File: rtl/binary_mul_n_1_bi.sv
// binary_mul_n_1_bi: iterative shift-add multiplier, signed or unsigned, one bit per enabled cycle
module binary_mul_n_1_bi #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  binary_mul_n_1_bi_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] ma, a_mag, b_mag;
  logic [2*WIDTH-1:0] acc, acc_nx, prod;
  logic [WIDTH:0] sum;
  logic neg, last, accept, busy_nx, done_nx;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else if (bus.en) state <= state_nx;

  always_comb begin
    accept = state == IDLE && bus.start;
    last = cnt == CW'(WIDTH - 1);
    state_nx = accept ? CALC : (state == CALC && last) ? DONE : (state == DONE) ? IDLE : state;
  end

  always_comb begin
    busy_nx = state_nx != IDLE;
    done_nx = state == CALC && last;
  end

  // Magnitudes are multiplied; the sign is reapplied on the final iteration before P loads
  always_comb begin
    a_mag = (bus.sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_mag = (bus.sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma} : '0);
    acc_nx = {sum, acc[WIDTH-1:1]};
    prod = neg ? -acc_nx : acc_nx;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      ma <= '0;
      acc <= '0;
      neg <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.P <= '0;
    end else if (bus.en) begin
      bus.busy <= busy_nx;
      bus.done <= done_nx;
      if (accept) begin
        cnt <= '0;
        ma <= a_mag;
        acc <= {{WIDTH{1'b0}}, b_mag};
        neg <= bus.sgn && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
      end else if (state == CALC) begin
        cnt <= cnt + CW'(1);
        acc <= acc_nx;
      end
      if (done_nx) bus.P <= prod;
    end
endmodule

// File: tb/tb_binary_mul_n_1_bi.sv
// tb_binary_mul_n_1_bi: directed and scoreboarded checks of the iterative multiplier
module tb_binary_mul_n_1_bi;
  logic clk = 1'b0;
  logic rst_n;
  int vectors = 0;
  int errors = 0;
  logic [15:0] sbq[$];
  logic d8_q = 1'b0;

  binary_mul_n_1_bi_if #(.WIDTH(8)) i8();
  binary_mul_n_1_bi_if #(.WIDTH(16)) i16();
  binary_mul_n_1_bi_if #(.WIDTH(4)) i4();

  binary_mul_n_1_bi #(.WIDTH(8)) u8(.clk(clk), .rst_n(rst_n), .bus(i8.slave));
  binary_mul_n_1_bi #(.WIDTH(16)) u16(.clk(clk), .rst_n(rst_n), .bus(i16.slave));
  binary_mul_n_1_bi #(.WIDTH(4)) u4(.clk(clk), .rst_n(rst_n), .bus(i4.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int x, y;
    x = s ? int'($signed(a)) : int'(a);
    y = s ? int'($signed(b)) : int'(b);
    return 16'(x * y);
  endfunction

  // Scoreboard: every rising done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (i8.done && !d8_q) begin
      chk("sb_nonempty", 32'(sbq.size() != 0), 1);
      if (sbq.size() != 0) chk("p8", i8.P, sbq.pop_front());
    end
    d8_q = i8.done;
  end

  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic s);
    int n, nb;
    @(negedge clk);
    i8.A = a; i8.B = b; i8.sgn = s; i8.start = 1'b1;
    sbq.push_back(model8(a, b, s));
    n = 0; nb = 0;
    do begin
      @(negedge clk);
      i8.start = 1'b0;
      n++;
      nb += int'(i8.busy);
    end while (!i8.done && n < 40);
    chk("lat8", n, 9);
    chk("busy8", nb, 9);
  endtask

  initial begin
    int n;
    logic [7:0] vals[10];
    vals = '{8'h80, 8'h81, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h3F, 8'h7F, 8'hC0, 8'h55};
    rst_n = 1'b0;
    i8.en = 1'b1; i8.start = 1'b0; i8.sgn = 1'b0; i8.A = '0; i8.B = '0;
    i16.en = 1'b1; i16.start = 1'b0; i16.sgn = 1'b0; i16.A = '0; i16.B = '0;
    i4.en = 1'b1; i4.start = 1'b0; i4.sgn = 1'b0; i4.A = '0; i4.B = '0;
    #2;
    chk("rst_busy", i8.busy, 0);
    chk("rst_done", i8.done, 0);
    chk("rst_p", i8.P, 0);
    @(negedge clk);
    rst_n = 1'b1;

    op(8'h80, 8'h80, 1'b1);
    chk("p_min_sq", i8.P, 32'h4000);
    op(8'hFF, 8'hFF, 1'b0);
    chk("p_uns_max", i8.P, 32'd65025);
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 10; i++)
        for (int j = 0; j < 10; j++)
          op(vals[i], vals[j], 1'(s));
    repeat (40) op(8'($urandom), 8'($urandom), 1'($urandom));

    // start held and operands changed during CALC
    @(negedge clk);
    i8.A = 8'd7; i8.B = 8'hFD; i8.sgn = 1'b1; i8.start = 1'b1;
    sbq.push_back(16'hFFEB);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 3) begin i8.A = 8'h55; i8.B = 8'h11; i8.sgn = 1'b0; end
    end while (!i8.done && n < 40);
    i8.start = 1'b0;
    chk("lat_hold", n, 9);
    chk("p_hold", i8.P, 32'hFFEB);
    repeat (15) @(negedge clk);
    chk("idle_after_hold", i8.busy, 0);

    // en stall mid-CALC, then stretched done
    @(negedge clk);
    i8.A = 8'd12; i8.B = 8'd11; i8.sgn = 1'b1; i8.start = 1'b1;
    sbq.push_back(16'd132);
    n = 0;
    do begin
      @(negedge clk);
      i8.start = 1'b0;
      n++;
      if (n == 3) begin
        i8.en = 1'b0;
        repeat (5) @(negedge clk);
        i8.en = 1'b1;
        n += 5;
      end
    end while (!i8.done && n < 40);
    chk("lat_stall", n, 14);
    i8.en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("done_hold", i8.done, 1);
    end
    chk("p_stall", i8.P, 32'd132);
    i8.en = 1'b1;
    @(negedge clk);
    chk("done_clr", i8.done, 0);
    chk("busy_clr", i8.busy, 0);

    // asynchronous reset mid-CALC aborts without done
    @(negedge clk);
    i8.A = 8'd50; i8.B = 8'd3; i8.sgn = 1'b0; i8.start = 1'b1;
    repeat (4) begin @(negedge clk); i8.start = 1'b0; end
    chk("busy_pre_rst", i8.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", i8.busy, 0);
    chk("arst_done", i8.done, 0);
    chk("arst_p", i8.P, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_idle", i8.busy, 0);
    op(8'hFF, 8'h01, 1'b1);
    chk("p_after_rst", i8.P, 32'hFFFF);

    // WIDTH=16 signed extremes
    @(negedge clk);
    i16.A = 16'h8000; i16.B = 16'h7FFF; i16.sgn = 1'b1; i16.start = 1'b1;
    n = 0;
    do begin @(negedge clk); i16.start = 1'b0; n++; end while (!i16.done && n < 60);
    chk("lat16", n, 17);
    chk("p16", i16.P, 32'hC0008000);

    // WIDTH=4 unsigned max
    @(negedge clk);
    i4.A = 4'hF; i4.B = 4'hF; i4.sgn = 1'b0; i4.start = 1'b1;
    n = 0;
    do begin @(negedge clk); i4.start = 1'b0; n++; end while (!i4.done && n < 30);
    chk("lat4", n, 5);
    chk("p4", i4.P, 32'd225);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
